// File: rtl/rip_bp_update_scheduler.sv
// Branch predictor table write-port sequencer: init sweep after reset/clear, then FIFO-drained updates.
// Latency: a queued update is written the cycle after acceptance; a stall holds the queue, never the sweep.
module rip_bp_update_scheduler #(
  parameter int INDEX_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 2,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_req,
  input  logic                          stall,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [INDEX_WIDTH-1:0]        upd_index,
  input  logic [WEIGHT_WIDTH-1:0]       upd_weight,
  input  logic                          upd_actual,
  output logic                          bp_update,
  output logic [INDEX_WIDTH-1:0]        bp_index,
  output logic [WEIGHT_WIDTH-1:0]       bp_weight,
  output logic                          bp_actual,
  output logic                          bp_sweep,
  output logic                          busy,
  output logic [$clog2(QUEUE_DEPTH):0]  q_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]          DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [INDEX_WIDTH-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {INIT, SWEEP, RUN} state_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0]  index;
    logic [WEIGHT_WIDTH-1:0] weight;
    logic                    actual;
  } entry_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] sweep_idx;
  entry_t                 mem [QUEUE_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   push;
  logic                   pop;
  entry_t                 head;

  // No bypass: a full queue refuses a push even if it pops this cycle.
  assign upd_ready = (state == RUN) && (count != DEPTH_C);
  assign pop       = (state == RUN) && !stall && (count != '0);
  assign push      = upd_valid && upd_ready && !clr_req;
  assign head      = mem[rd_ptr];
  assign busy      = (state != RUN);
  assign q_count   = count;

  always_comb begin
    bp_update = 1'b0;
    bp_sweep  = 1'b0;
    bp_index  = '0;
    bp_weight = '0;
    bp_actual = 1'b0;
    case (state)
      SWEEP: begin
        bp_update = 1'b1;
        bp_sweep  = 1'b1;
        bp_index  = sweep_idx;
        bp_actual = 1'b1;
      end
      RUN: begin
        bp_update = pop;
        bp_index  = head.index;
        bp_weight = head.weight;
        bp_actual = head.actual;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      sweep_idx <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        INIT: begin
          state     <= SWEEP;
          sweep_idx <= '0;
        end
        SWEEP: begin
          if (clr_req) begin
            sweep_idx <= '0;
          end else if (sweep_idx == IDX_MAX) begin
            state     <= RUN;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        RUN: begin
          // Queued weights are stale after a clear, so the queue is dropped.
          if (clr_req) begin
            state     <= SWEEP;
            sweep_idx <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
          end else begin
            if (push) begin
              mem[wr_ptr] <= '{index: upd_index, weight: upd_weight, actual: upd_actual};
              wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/rip_bp_update_scheduler.md
# rip_bp_update_scheduler

Sequencer and write-port arbiter for the branch predictor pattern table. After reset or a clear request, it sweeps every table entry to weakly-untaken. In normal operation, it buffers resolved-branch updates from the commit stage in a small FIFO and drains them one per non-stalled cycle into the predictor's single update port. It sits between the commit/branch-resolution logic and `rip_branch_predictor`'s `update`/`update_index`/`update_weight`/`actual` inputs.

## Interface
- `INDEX_WIDTH`, 10, table index width; the table has 2^INDEX_WIDTH entries.
- `WEIGHT_WIDTH`, 2, width of a saturating-counter weight.
- `QUEUE_DEPTH`, 4, update FIFO entries; must be a power of 2, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clr_req` in 1: single-cycle pulse requesting a full table re-initialisation.
- `stall` in 1: pipeline stall; blocks draining of the FIFO.
- `upd_valid` in 1: a resolved-branch update is offered.
- `upd_ready` out 1: FIFO accepts the update; the transfer happens when `upd_valid & upd_ready`.
- `upd_index` in INDEX_WIDTH: table index captured at prediction time.
- `upd_weight` in WEIGHT_WIDTH: weight read at prediction time.
- `upd_actual` in 1: actual branch outcome.
- `bp_update` out 1: predictor table write strobe.
- `bp_index` out INDEX_WIDTH: write index.
- `bp_weight` out WEIGHT_WIDTH: old weight presented to the predictor's update logic.
- `bp_actual` out 1: outcome presented to the predictor's update logic.
- `bp_sweep` out 1: high when the current write is an init sweep write; the predictor must not shift global history when this is high.
- `busy` out 1: high during INIT and SWEEP; the frontend must not predict while it is high.
- `q_count` out $clog2(QUEUE_DEPTH)+1: FIFO occupancy.

## Operation
- FSM states:
  - INIT: reset state; lasts exactly one cycle, then goes to SWEEP.
  - SWEEP: writes index `sweep_idx` each cycle with `bp_weight`=2'b00 (strongly untaken) and `bp_actual`=1, so the stored value is weakly untaken (2'b01).
    - `sweep_idx` increments every cycle and ignores `stall`.
    - When `sweep_idx` = 2^INDEX_WIDTH−1 has been written, the FSM goes to RUN and `sweep_idx` returns to 0.
  - RUN: drains the FIFO.
- `clr_req` in RUN: goes to SWEEP at the next edge; `sweep_idx` = 0; FIFO flushed (`q_count` → 0) because queued weights are stale.
- `clr_req` in SWEEP: `sweep_idx` restarts at 0. `clr_req` in INIT is ignored.
- `upd_ready` = (state == RUN) & (`q_count` < QUEUE_DEPTH). There is no bypass: a full FIFO refuses a push even when a pop happens in the same cycle.
- Drain condition `pop` = (state == RUN) & ~`stall` & (`q_count` ≠ 0).
  - In RUN, `bp_update` = `pop`, and `bp_index`/`bp_weight`/`bp_actual` show the FIFO head combinationally.
  - In SWEEP, `bp_update` = 1 and `bp_sweep` = 1.
  - In all other cases `bp_update` = 0 and `bp_sweep` = 0.
- Simultaneous push and pop: `q_count` is unchanged, the head advances, and the new entry goes in at the tail.
- A push in the same cycle as `clr_req` is discarded; `upd_ready` is already high that cycle, so the producer sees the update as consumed.
- The read/write pointers are log2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH. `q_count` saturates logically at QUEUE_DEPTH and is never exceeded.
- Same-index updates already in the queue are not merged; each writes in order.

## Timing
- Reset values:
  - state INIT, `sweep_idx` 0, pointers 0, `q_count` 0.
  - `bp_update` 0, `bp_sweep` 0, `upd_ready` 0, `busy` 1.
  - `bp_index`, `bp_weight`, `bp_actual` 0.
- After `rst` deasserts:
  - Cycle 0 is INIT.
  - Cycles 1 to 2^INDEX_WIDTH are SWEEP, one write per cycle.
  - The first RUN cycle is 2^INDEX_WIDTH+1; `busy` falls there and `upd_ready` rises there.
- Update latency: an update accepted at edge k with an empty queue and no stall has `bp_update` high in the cycle after k and is written at edge k+1.
- Throughput: one write per non-stalled cycle; a full queue drains in QUEUE_DEPTH non-stalled cycles.
- `rst` mid-operation: everything asynchronously returns to the reset values; queue contents are lost and the sweep restarts after release.

## Test plan
Bench uses INDEX_WIDTH=4, QUEUE_DEPTH=4.
- Reset release:
  - Required: one INIT cycle, then 16 consecutive writes with `bp_index` 0..15, `bp_weight`=0, `bp_actual`=1, `bp_sweep`=1.
  - Then `busy`=0 and `upd_ready`=1 in cycle 17.
- Single update {idx 5, weight 2, actual 0} in RUN, no stall:
  - Required: the next cycle shows `bp_update`=1, `bp_index`=5, `bp_weight`=2, `bp_actual`=0.
  - `q_count` goes 1 → 0.
- Hold `stall`=1 and offer 6 back-to-back updates:
  - Required: 4 accepted, `upd_ready`=0 at `q_count`=4.
  - On stall release, 4 writes in FIFO order; the producer's remaining 2 are accepted as space frees.
- Push and pop in the same cycle at `q_count`=2:
  - Required: `q_count` stays 2 and the write order is preserved.
  - Continue across the pointer wrap (10 updates) with no reordering.
- `clr_req` with 3 entries queued:
  - Required: `q_count`=0 next cycle and a 16-write sweep.
  - A second `clr_req` at sweep index 7 restarts the sweep at 0; none of the queued entries are ever written.
- Assert `rst` mid-drain with 2 queued:
  - Required: all outputs reach their reset values immediately without waiting for a clock edge, followed by INIT and a full sweep after release.
